// File: rtl/tree_result_accumulator.sv
// -----------------------------------------------------------------------------
// tree_result_accumulator
//
// Purpose:
//   Sits behind a pipelined adder tree. It follows each chunk through the tree
//   with a {valid,last} tag pipe. When a tagged sum reaches the tree output, it
//   is added into a per-element accumulator. Each finished element, together
//   with its index, is pushed into a small result FIFO that a valid/ready
//   consumer drains.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   done            tree clock enable; tags advance and sums are consumed only
//                   on edges where done=1
//   in_valid        chunk entering the tree this cycle is real
//   in_last         chunk entering the tree ends its output element
//   op1             adder-tree sum output
//   res_data        FIFO head sum (0 when empty)
//   res_index       FIFO head element index (0 when empty)
//   res_valid       FIFO non-empty
//   res_ready       consumer takes the head this cycle
//   hold_req        registered request for upstream to stop issuing chunks
//   ovf             sticky signed-overflow flag
//   drop_err        sticky flag: a finished element was lost to a full FIFO
//   busy            partial sum held or tags still in flight
// -----------------------------------------------------------------------------
module tree_result_accumulator #(
    parameter int DATA_W     = 64,
    parameter int TREE_LAT   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_index,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              hold_req,
    output logic              ovf,
    output logic              drop_err,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // The occupancy sum adds the FIFO count and every valid tag, so it needs
    // headroom for both.
    localparam int OCC_W = CNT_W + $clog2(TREE_LAT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [OCC_W-1:0] OCC_HOLD = OCC_W'(FIFO_DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]      elem_idx_q, elem_idx_d;
    logic [TREE_LAT-1:0]   tag_valid_q, tag_valid_d;
    logic [TREE_LAT-1:0]   tag_last_q, tag_last_d;
    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_d [FIFO_DEPTH];
    logic [IDX_W-1:0]      fifo_idx_q  [FIFO_DEPTH];
    logic [IDX_W-1:0]      fifo_idx_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  drop_err_q, drop_err_d;
    logic                  hold_req_q, hold_req_d;

    logic                  capture;
    logic                  cap_last;
    logic                  push;
    logic                  push_write;
    logic                  pop;
    logic                  fifo_full;
    logic [DATA_W-1:0]     add_a;
    logic [DATA_W-1:0]     sum;
    logic                  add_ovf;
    logic [OCC_W-1:0]      occ;

    // The head of the tag pipe lines up with op1. A sum is consumed only on an
    // enabled edge, so a sum frozen while done=0 is counted exactly once.
    always_comb begin
        capture   = done & tag_valid_q[TREE_LAT-1];
        cap_last  = tag_last_q[TREE_LAT-1];
        push      = capture & cap_last;
        pop       = (count_q != '0) & res_ready;
        fifo_full = (count_q == CNT_FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_write = push & (~fifo_full | pop);

        // In IDLE the accumulator is logically empty, so the add starts from 0.
        add_a   = (state_q == ACC) ? acc_q : '0;
        sum     = add_a + op1;
        add_ovf = (add_a[DATA_W-1] == op1[DATA_W-1]) &&
                  (sum[DATA_W-1] != op1[DATA_W-1]);
    end

    // Next-state computation for the tag pipe, FSM, FIFO and sticky flags.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        elem_idx_d  = elem_idx_q;
        tag_valid_d = tag_valid_q;
        tag_last_d  = tag_last_q;
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        drop_err_d  = drop_err_q;
        occ         = '0;

        if (done) begin
            tag_valid_d[0] = in_valid;
            tag_last_d[0]  = in_last;
            for (int i = 1; i < TREE_LAT; i++) begin
                tag_valid_d[i] = tag_valid_q[i-1];
                tag_last_d[i]  = tag_last_q[i-1];
            end
        end

        if (capture) begin
            if (add_ovf) begin
                ovf_d = 1'b1;
            end
            if (cap_last) begin
                state_d = IDLE;
                acc_d   = '0;
            end else begin
                state_d = ACC;
                acc_d   = sum;
            end
        end

        // The index advances on every finished element, including dropped
        // ones, so the consumer can spot the lost indices.
        if (push) begin
            elem_idx_d = elem_idx_q + IDX_ONE;
            if (push_write) begin
                fifo_data_d[wr_ptr_q] = sum;
                fifo_idx_d[wr_ptr_q]  = elem_idx_q;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
            end else begin
                drop_err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push_write && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_write && pop) begin
            count_d = count_q - CNT_ONE;
        end

        // Every valid tag may turn into a push. Counting them against the
        // FIFO space leaves one slot of slack for the cycle upstream needs to react.
        occ = OCC_W'(count_d);
        for (int i = 0; i < TREE_LAT; i++) begin
            occ = occ + OCC_W'(tag_valid_d[i]);
        end
        hold_req_d = (occ >= OCC_HOLD);
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            elem_idx_q  <= '0;
            tag_valid_q <= '0;
            tag_last_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drop_err_q  <= 1'b0;
            hold_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            elem_idx_q  <= elem_idx_d;
            tag_valid_q <= tag_valid_d;
            tag_last_q  <= tag_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_idx_q  <= fifo_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drop_err_q  <= drop_err_d;
            hold_req_q  <= hold_req_d;
        end
    end

    // The outputs are decoded from registered state only. The head reads as
    // zero while the FIFO is empty.
    always_comb begin
        res_valid = (count_q != '0);
        res_data  = res_valid ? fifo_data_q[rd_ptr_q] : '0;
        res_index = res_valid ? fifo_idx_q[rd_ptr_q]  : '0;
        hold_req  = hold_req_q;
        ovf       = ovf_q;
        drop_err  = drop_err_q;
        busy      = (state_q == ACC) | (|tag_valid_q);
    end

endmodule

// File: tb/tb_tree_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_tree_result_accumulator
//
// Drives chunk sums through a behavioural stand-in for the 4-level adder tree.
// The stand-in is a done-gated delay line. A table of per-cycle vectors covers
// back-to-back single-chunk elements. Hand-written sequences cover the
// multi-chunk, done-gap, backpressure, overflow and mid-element reset cases.
// A second instance with a 2-bit index shares all inputs to show index wrap.
// -----------------------------------------------------------------------------
module tb_tree_result_accumulator;

    logic        clk;
    logic        rst;
    logic        done;
    logic        in_valid;
    logic        in_last;
    logic [63:0] op1;
    logic [63:0] chunk_sum;
    logic        res_ready;

    logic [63:0] res_data;
    logic [15:0] res_index;
    logic        res_valid;
    logic        hold_req;
    logic        ovf;
    logic        drop_err;
    logic        busy;

    logic [63:0] res_data_n;
    logic [1:0]  res_index_n;
    logic        res_valid_n;
    logic        hold_req_n;
    logic        ovf_n;
    logic        drop_err_n;
    logic        busy_n;

    logic [63:0] tree_pipe [4];

    int total;
    int bad;

    tree_result_accumulator #(
        .DATA_W(64), .TREE_LAT(4), .FIFO_DEPTH(4), .IDX_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .done(done), .in_valid(in_valid),
        .in_last(in_last), .op1(op1), .res_data(res_data),
        .res_index(res_index), .res_valid(res_valid), .res_ready(res_ready),
        .hold_req(hold_req), .ovf(ovf), .drop_err(drop_err), .busy(busy)
    );

    tree_result_accumulator #(
        .DATA_W(64), .TREE_LAT(4), .FIFO_DEPTH(4), .IDX_W(2)
    ) u_dut_narrow (
        .clk(clk), .rst(rst), .done(done), .in_valid(in_valid),
        .in_last(in_last), .op1(op1), .res_data(res_data_n),
        .res_index(res_index_n), .res_valid(res_valid_n), .res_ready(res_ready),
        .hold_req(hold_req_n), .ovf(ovf_n), .drop_err(drop_err_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the adder tree: four enable-gated register levels.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) tree_pipe[i] <= 64'd0;
        end else if (done) begin
            tree_pipe[0] <= chunk_sum;
            tree_pipe[1] <= tree_pipe[0];
            tree_pipe[2] <= tree_pipe[1];
            tree_pipe[3] <= tree_pipe[2];
        end
    end
    assign op1 = tree_pipe[3];

    typedef struct {
        logic        v;
        logic        l;
        logic [63:0] c;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic [15:0] exp_index;
        logic        exp_busy;
        logic        exp_hold;
    } vec_t;

    vec_t tbl [10];

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic d, input logic v, input logic l,
                                 input logic [63:0] c, input logic r);
        done      = d;
        in_valid  = v;
        in_last   = l;
        chunk_sum = c;
        res_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        done      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chunk_sum = 64'd0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Back-to-back single-chunk elements 1..5 with the consumer always ready.
        tbl[0] = '{1'b1, 1'b1, 64'd1, 1'b0, 64'd0, 16'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 64'd2, 1'b0, 64'd0, 16'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 64'd3, 1'b0, 64'd0, 16'd0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 64'd4, 1'b0, 64'd0, 16'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 64'd5, 1'b1, 64'd1, 16'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 64'd0, 1'b1, 64'd2, 16'd1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 64'd0, 1'b1, 64'd3, 16'd2, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 64'd0, 1'b1, 64'd4, 16'd3, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 64'd0, 1'b1, 64'd5, 16'd4, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 16'd0, 1'b0, 1'b0};

        // Reset state, checked while rst is still high.
        rst = 1'b1; done = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chunk_sum = 64'd0; res_ready = 1'b0;
        #1;
        checkOutput("rst res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst res_data", res_data, 64'd0);
        checkOutput("rst res_index", 64'(res_index), 64'd0);
        checkOutput("rst hold_req", 64'(hold_req), 64'd0);
        checkOutput("rst ovf", 64'(ovf), 64'd0);
        checkOutput("rst drop_err", 64'(drop_err), 64'd0);
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst narrow flags",
                    64'({res_valid_n, hold_req_n, ovf_n, drop_err_n, busy_n}), 64'd0);
        doReset();

        // Table: single-chunk elements.
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, tbl[j].v, tbl[j].l, tbl[j].c, 1'b1);
            checkOutput($sformatf("tbl%0d res_valid", j), 64'(res_valid), 64'(tbl[j].exp_valid));
            checkOutput($sformatf("tbl%0d res_data", j), res_data, tbl[j].exp_data);
            checkOutput($sformatf("tbl%0d res_index", j), 64'(res_index), 64'(tbl[j].exp_index));
            checkOutput($sformatf("tbl%0d busy", j), 64'(busy), 64'(tbl[j].exp_busy));
            checkOutput($sformatf("tbl%0d hold_req", j), 64'(hold_req), 64'(tbl[j].exp_hold));
            checkOutput($sformatf("tbl%0d narrow data", j), res_data_n, tbl[j].exp_data);
            checkOutput($sformatf("tbl%0d narrow index", j), 64'(res_index_n),
                        64'(tbl[j].exp_index[1:0]));
        end

        // Three-chunk element 10+20+30 with done held high.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd10, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd20, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd30, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("multi pre res_valid", 64'(res_valid), 64'd0);
        checkOutput("multi pre busy", 64'(busy), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("multi res_valid", 64'(res_valid), 64'd1);
        checkOutput("multi res_data", res_data, 64'd60);
        checkOutput("multi res_index", 64'(res_index), 64'd0);
        checkOutput("multi busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("multi popped valid", 64'(res_valid), 64'd0);
        checkOutput("multi popped data", res_data, 64'd0);

        // The same element with done gaps; a frozen sum must not be re-added.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd10, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd20, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd30, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            applyStimulus((cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, 1'b0, 64'd0, 1'b0);
            if (res_valid) break;
        end
        checkOutput("gap res_valid", 64'(res_valid), 64'd1);
        checkOutput("gap res_data", res_data, 64'd60);
        checkOutput("gap res_index", 64'(res_index), 64'd0);

        // Backpressure: six elements 11..16 pushed while hold_req is ignored.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd11, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd12, 1'b0);
        checkOutput("bp hold early", 64'(hold_req), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd13, 1'b0);
        checkOutput("bp hold at 3", 64'(hold_req), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd14, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd15, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd16, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("bp drop before full", 64'(drop_err), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("bp drop_err", 64'(drop_err), 64'd1);
        checkOutput("bp busy idle", 64'(busy), 64'd0);
        checkOutput("bp hold full", 64'(hold_req), 64'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bp drain%0d valid", k), 64'(res_valid), 64'd1);
            checkOutput($sformatf("bp drain%0d data", k), res_data, 64'(11 + k));
            checkOutput($sformatf("bp drain%0d index", k), 64'(res_index), 64'(k));
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        end
        checkOutput("bp drained valid", 64'(res_valid), 64'd0);
        checkOutput("bp drained hold", 64'(hold_req), 64'd0);
        checkOutput("bp drop sticky", 64'(drop_err), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd99, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("bp next data", res_data, 64'd99);
        checkOutput("bp next index", 64'(res_index), 64'd6);

        // Signed overflow: max positive plus one.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("ovf pre flag", 64'(ovf), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("ovf res_data", res_data, 64'h8000_0000_0000_0000);
        checkOutput("ovf flag", 64'(ovf), 64'd1);

        // Reset mid-element: two of three chunks captured, third tag in flight,
        // with one result still unread and ovf still set.
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd100, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd200, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd300, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("midrst busy before", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst res_valid", 64'(res_valid), 64'd0);
        checkOutput("midrst res_data", res_data, 64'd0);
        checkOutput("midrst res_index", 64'(res_index), 64'd0);
        checkOutput("midrst ovf", 64'(ovf), 64'd0);
        checkOutput("midrst busy", 64'(busy), 64'd0);
        checkOutput("midrst hold/drop", 64'({hold_req, drop_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd7, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd8, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("post rst pre valid", 64'(res_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("post rst valid", 64'(res_valid), 64'd1);
        checkOutput("post rst data", res_data, 64'd15);
        checkOutput("post rst index", 64'(res_index), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tree_result_accumulator.md
Name: tree_result_accumulator

Overview:
- Sits directly downstream of the 16-input, 4-level pipelined 64-bit adder tree.
- Consumes the tree's single 64-bit sum (op1) once per enabled cycle.
- Accumulates successive tree sums belonging to one output element, i.e. one dot product split into 16-product chunks.
- Pushes each finished element, with its index, into a small output FIFO drained by a valid/ready writer.

Parameters:
- DATA_W, 64, width of tree sum and accumulator.
- TREE_LAT, 4, enabled-cycle latency of the adder tree (4 adder levels, 1 register each).
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2).
- IDX_W, 16, width of output element index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- done  in  1  adder-tree clock enable; same net that drives the tree CE.
- in_valid  in  1  lane products entering the tree this cycle are real; sampled only when done=1.
- in_last  in  1  this chunk is the final chunk of the current output element; sampled with in_valid.
- op1  in  DATA_W  adder-tree sum output.
- res_data  out  DATA_W  completed element sum (FIFO head).
- res_index  out  IDX_W  element index of FIFO head.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  consumer accepts the head this cycle.
- hold_req  out  1  upstream controller must deassert done next cycle.
- ovf  out  1  sticky signed-overflow flag.
- drop_err  out  1  sticky flag: a result was lost to a full FIFO.
- busy  out  1  partial sum held or any tag in flight.

Behaviour:
- Reset (async, rst=1) clears everything:
  - tag pipe cleared; in-flight tags discarded.
  - acc=0, elem_idx=0, FIFO emptied.
  - res_valid=0, res_data=0, res_index=0.
  - hold_req=0, ovf=0, drop_err=0, busy=0.
- Tag pipe: TREE_LAT stages of {valid,last}. Advances only on edges where done=1:
  - t[0] <= {in_valid, in_last}.
  - t[i] <= t[i-1].
  - With done=0 the pipe holds, exactly mirroring the frozen tree.
- Alignment: when t[TREE_LAT-1].valid=1, op1 is the sum of the chunk that carried that tag.
- Capture: op1 is consumed on a clk edge only when t[TREE_LAT-1].valid=1 AND done=1.
  - If done=0, op1 is held and consumed on the first later edge with done=1. No double-count.
- FSM:
  - IDLE: no partial sum.
  - ACC: partial sum in acc.
  - IDLE + capture, last=0: acc<=op1; go to ACC.
  - IDLE + capture, last=1: push op1; stay IDLE.
  - ACC + capture, last=0: acc<=acc+op1; stay ACC.
  - ACC + capture, last=1: push acc+op1; acc<=0; go to IDLE.
- Arithmetic:
  - DATA_W two's-complement add, wraps modulo 2^DATA_W.
  - ovf is set when both operands have equal sign and the result sign differs. Cleared only by rst.
- Push:
  - Writes {sum, elem_idx} to the FIFO; elem_idx then increments, wrapping 2^IDX_W-1 -> 0.
  - If the FIFO is full and no pop occurs in the same cycle: result discarded, drop_err<=1, elem_idx still increments.
- Pop: res_valid && res_ready removes the head. res_data/res_index show the head; both are 0 when empty.
- Simultaneous push and pop:
  - Allowed in any state, including full. Count unchanged.
  - When empty, push and pop never coincide, since res_valid=0.
- hold_req: registered, equals (next FIFO count + number of valid tags in the pipe) >= FIFO_DEPTH-1. This guarantees no drop if the controller obeys it within 1 cycle.
- busy = (state==ACC) | OR of all t[i].valid.
- Latency: result is visible on res_valid 1 clk after the capturing edge of its last chunk, which is TREE_LAT enabled edges after the last chunk entered.

Test Plan:
- Single element, 3 chunks, done=1 continuously, op1 sums 10, 20, 30 -> one result, res_data=60, res_index=0, 1 cycle after 3rd capture; FIFO returns empty after pop.
- Single-chunk elements: 5 back-to-back chunks, in_last=1, sums 1..5, res_ready=1 -> results 1,2,3,4,5 with indices 0..4, no gaps.
- done gaps: done toggles 1,0,0,1 around capture, same 3-chunk stimulus as the first scenario -> res_data=60; acc never double-adds while done=0.
- Backpressure: res_ready=0, 6 single-chunk elements pushed while ignoring hold_req:
  - 4 stored; 5th and 6th dropped; drop_err=1.
  - hold_req asserted by the time count+in-flight reaches 3.
  - After draining, indices read 0,1,2,3.
- Overflow/wrap: chunks 0x7FFF_FFFF_FFFF_FFFF then 1 -> res_data=0x8000_0000_0000_0000, ovf=1. Index wrap with IDX_W=2: 5th result carries index 0.
- Reset mid-element: assert rst after 2 of 3 chunks and with tags in flight -> all outputs 0 immediately. The next 2-chunk element (7, 8) yields 15 at index 0.
